wb_stage_p: RTL
===============

# wb_stage_p

Parametrised registered writeback stage between the memory stage and the register file. Captures one retiring instruction per cycle under a valid/stall handshake, aligns and sign/zero-extends load data, selects the writeback source, suppresses writes to x0, and optionally counts retired instructions. Output is registered, so the register-file write happens one cycle after capture.

## Interface
- XLEN, 32: datapath width; 32 or 64.
- REG_AW, 5: register address width.
- CNT_W, 64: retire counter width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  instruction present at the stage input.
- i_stall  in  1  hold; no capture this cycle.
- i_flush  in  1  kill the incoming instruction.
- i_reg_write  in  1  instruction writes rd.
- i_rd  in  REG_AW  destination register.
- i_resultsrc  in  2  00 ALU result, 01 load data, 10 PC+4, 11 CSR read data.
- i_result  in  XLEN  ALU result.
- i_load_data  in  XLEN  raw memory word.
- i_addr_lo  in  2  low address bits of the load.
- i_funct3  in  3  load type.
- i_pc_4  in  XLEN  PC+4.
- i_csr_data  in  XLEN  CSR read value.
- o_rf_wr  out  1  register-file write enable.
- o_rf_addr  out  REG_AW  write address.
- o_rf_data  out  XLEN  write data.
- o_retire  out  1  one-cycle pulse per retired instruction.
- o_instret  out  CNT_W  retired-instruction count.

## Operation
- Capture when i_valid & ~i_stall & ~i_flush. i_flush beats i_valid. i_stall with no flush blocks capture.
- Each captured instruction produces exactly one cycle with o_retire=1. That pulse also drives o_rf_wr = i_reg_write & (i_rd != 0).
- A cycle with no capture clears o_rf_wr and o_retire on the next edge. o_rf_addr and o_rf_data hold their last values.
- Source select (combinational, registered once):
  - 00 selects i_result.
  - 01 selects the aligned load.
  - 10 selects i_pc_4.
  - 11 selects i_csr_data.
- Load alignment:
  - LB (000) and LBU (100) take byte i_addr_lo.
  - LH (001) and LHU (101) take halfword i_addr_lo[1]; i_addr_lo[0] is ignored.
  - LW (010) takes bits [31:0]. Sign-extend when XLEN=64; zero upper bits for LWU (110).
  - LD (011) takes the full word and is valid only when XLEN=64; for XLEN=32 it equals LW.
  - 111 passes i_load_data unchanged.
  - Signed loads sign-extend to XLEN; unsigned loads zero-extend.
- rd=0 with i_reg_write=1 still retires. o_rf_wr stays 0.
- o_instret increments by 1 on each o_retire pulse and wraps from all-ones to 0.

## Timing
- Latency: the capture edge N drives the outputs during cycle N+1. Throughput is 1 per cycle.
- Back-to-back captures give consecutive o_rf_wr pulses with no bubble.
- Reset values: o_rf_wr=0, o_retire=0, o_rf_addr=0, o_rf_data=0, o_instret=0.
- rst asserted mid-operation clears everything immediately, with no clock edge needed. A pending write is lost, not delayed.
- After rst deasserts, the first capture is possible on the next rising edge.
- i_stall and i_flush together: flush has priority, and the result is a bubble.
- The o_instret increment is visible in the same cycle as the o_retire pulse: the counter updates on the capture edge together with o_retire.

## Configuration
- WB_INSTRET_EN defined: the CNT_W retire counter is built and o_instret counts as above.
- WB_INSTRET_EN undefined: no counter flops are built. o_instret is tied to 0. o_retire behaves identically.

## Test plan
- Reset then ALU write: rst pulse; then i_valid=1, i_reg_write=1, i_rd=5, resultsrc=00, i_result=0x1234_5678 -> next cycle o_rf_wr=1, o_rf_addr=5, o_rf_data=0x1234_5678, o_instret=1. The cycle after, o_rf_wr=0.
- Load alignment:
  - i_load_data=0x8899_AABB, addr_lo=2, LB -> o_rf_data=0xFFFF_FF99.
  - Same stimulus with LBU -> 0x0000_0099.
  - addr_lo=3, LH -> 0xFFFF_8899 (the addr_lo[0] ignore rule).
- x0 write: i_rd=0, i_reg_write=1, three captures -> o_rf_wr stays 0 throughout; o_retire pulses 3 times; o_instret=3.
- Stall/flush:
  - valid with stall=1 for 4 cycles -> no o_retire.
  - valid+stall+flush -> no o_retire.
  - stall released -> exactly one o_retire, carrying PC+4 (resultsrc=10, i_pc_4=0x104 -> o_rf_data=0x104).
- Async reset mid-stream: assert rst between clock edges after a capture -> o_rf_wr and o_instret are 0 before the next edge.
- Wrap and config: with CNT_W=4 and WB_INSTRET_EN, 17 retirements -> o_instret=1. Without the macro, o_instret=0 throughout.

Source files
------------

// File: rtl/wb_stage_p.sv
// wb_stage_p: registered writeback stage with load alignment and x0 suppression.
// Optional retire counter built when WB_INSTRET_EN is defined.
module wb_stage_p #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              i_reg_write,
    input  logic [REG_AW-1:0] i_rd,
    input  logic [1:0]        i_resultsrc,
    input  logic [XLEN-1:0]   i_result,
    input  logic [XLEN-1:0]   i_load_data,
    input  logic [1:0]        i_addr_lo,
    input  logic [2:0]        i_funct3,
    input  logic [XLEN-1:0]   i_pc_4,
    input  logic [XLEN-1:0]   i_csr_data,
    output logic              o_rf_wr,
    output logic [REG_AW-1:0] o_rf_addr,
    output logic [XLEN-1:0]   o_rf_data,
    output logic              o_retire,
    output logic [CNT_W-1:0]  o_instret
);

    logic            cap;
    logic [7:0]      ld_b;
    logic [15:0]     ld_h;
    logic [31:0]     ld_w;
    logic [XLEN-1:0] ld_val;
    logic [XLEN-1:0] wb_data;

    assign cap  = i_valid & ~i_stall & ~i_flush;
    assign ld_w = i_load_data[31:0];
    assign ld_h = i_addr_lo[1] ? ld_w[31:16] : ld_w[15:0];

    always_comb begin
        ld_b = ld_w[7:0];
        unique case (i_addr_lo)
            2'd0: ld_b = ld_w[7:0];
            2'd1: ld_b = ld_w[15:8];
            2'd2: ld_b = ld_w[23:16];
            2'd3: ld_b = ld_w[31:24];
        endcase
    end

    // LD on a 32-bit datapath collapses to LW since the full word is 32 bits
    always_comb begin
        ld_val = i_load_data;
        unique case (i_funct3)
            3'b000: ld_val = XLEN'($signed(ld_b));
            3'b001: ld_val = XLEN'($signed(ld_h));
            3'b010: ld_val = XLEN'($signed(ld_w));
            3'b011: ld_val = i_load_data;
            3'b100: ld_val = XLEN'(ld_b);
            3'b101: ld_val = XLEN'(ld_h);
            3'b110: ld_val = XLEN'(ld_w);
            3'b111: ld_val = i_load_data;
        endcase
    end

    always_comb begin
        wb_data = i_result;
        unique case (i_resultsrc)
            2'b00: wb_data = i_result;
            2'b01: wb_data = ld_val;
            2'b10: wb_data = i_pc_4;
            2'b11: wb_data = i_csr_data;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rf_wr   <= 1'b0;
            o_retire  <= 1'b0;
            o_rf_addr <= '0;
            o_rf_data <= '0;
        end else begin
            o_rf_wr  <= cap & i_reg_write & (|i_rd);
            o_retire <= cap;
            if (cap) begin
                o_rf_addr <= i_rd;
                o_rf_data <= wb_data;
            end
        end
    end

`ifdef WB_INSTRET_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_instret <= '0;
        end else if (cap) begin
            o_instret <= o_instret + CNT_W'(1);
        end
    end
`else
    assign o_instret = '0;
`endif

endmodule
